// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit: size encoding, FSM states,
// default data memory size and a size-to-byte-count helper.
package mau_pkg;

    localparam int unsigned MAU_MEM_BYTES = 1024;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2,
        SizeRsvd = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StSplit  = 2'd2,
        StResp   = 2'd3
    } state_e;

    // Reserved size maps to 4; such requests are rejected before any transfer.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size_e'(size))
            SizeByte: return 3'd1;
            SizeHalf: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mau_load_align.sv
// Combinational load path: merges returned memory data into the assembly word and
// extends the assembled value to 32 bits by size and signedness.
module mau_load_align
    import mau_pkg::*;
(
    input  logic [31:0] i_asm,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_split,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_asm_next,
    output logic [31:0] o_rdata
);

    always_comb begin
        o_asm_next = i_mem_rdata;
        if (i_split) begin
            // Split transfers return one byte right-justified; it lands in lane k.
            o_asm_next = i_asm;
            o_asm_next[{i_lane, 3'b000} +: 8] = i_mem_rdata[7:0];
        end
    end

    always_comb begin
        case (size_e'(i_size))
            SizeByte: o_rdata = {{24{i_signed & i_asm[7]}}, i_asm[7:0]};
            SizeHalf: o_rdata = {{16{i_signed & i_asm[15]}}, i_asm[15:0]};
            default:  o_rdata = i_asm;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a byte-addressed datamem: aligned requests take one
// access, misaligned ones are split into byte transfers, out-of-range ones are rejected.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MAU_MEM_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [31:0] mem_read_data
);

    state_e      r_state;
    state_e      w_state_next;
    logic        r_write;
    logic        r_signed;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_asm;
    logic [1:0]  r_size;
    logic [1:0]  r_cnt;

    logic [2:0]  w_nbytes;
    logic [2:0]  w_r_nbytes;
    logic [32:0] w_end;
    logic        w_req_err;
    logic        w_req_misaligned;
    logic        w_accept;
    logic [7:0]  w_wbyte;
    logic [31:0] w_asm_next;
    logic [31:0] w_ext;

    assign w_nbytes   = size_nbytes(req_size);
    assign w_r_nbytes = size_nbytes(r_size);
    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    assign w_end      = {1'b0, req_addr} + {30'd0, w_nbytes};
    assign w_req_err  = (size_e'(req_size) == SizeRsvd) || (w_end > 33'(MEM_BYTES));
    assign w_req_misaligned = (req_addr[1:0] & (w_nbytes[1:0] - 2'd1)) != 2'd0;

    assign req_ready = (r_state == StIdle);
    assign w_accept  = req_valid && req_ready;
    assign w_wbyte   = r_wdata[{r_cnt, 3'b000} +: 8];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state_next = StResp;
                    end else if (w_req_misaligned) begin
                        w_state_next = StSplit;
                    end else begin
                        w_state_next = StAccess;
                    end
                end
            end
            StAccess: w_state_next = StResp;
            StSplit: begin
                if ({1'b0, r_cnt} == w_r_nbytes - 3'd1) begin
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Enables are gated by reset so an aborting edge never completes a transfer.
    always_comb begin
        mem_address      = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_data   = '0;
        mem_xfer_size    = 4'd4;
        if (!reset) begin
            case (r_state)
                StAccess: begin
                    mem_address      = r_addr;
                    mem_xfer_size    = {1'b0, w_r_nbytes};
                    mem_write_enable = r_write;
                    mem_read_enable  = !r_write;
                    mem_write_data   = r_wdata;
                end
                StSplit: begin
                    mem_address      = r_addr + {30'd0, r_cnt};
                    mem_xfer_size    = 4'd1;
                    mem_write_enable = r_write;
                    mem_read_enable  = !r_write;
                    mem_write_data   = {24'd0, w_wbyte};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_asm    <= '0;
            r_size   <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write  <= req_write;
                r_signed <= req_signed;
                r_err    <= w_req_err;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_size   <= req_size;
                r_cnt    <= '0;
                r_asm    <= '0;
            end else begin
                if (r_state == StSplit) begin
                    r_cnt <= r_cnt + 2'd1;
                end
                if ((r_state == StAccess || r_state == StSplit) && !r_write) begin
                    r_asm <= w_asm_next;
                end
            end
        end
    end

    mau_load_align u_load_align (
        .i_asm       (r_asm),
        .i_mem_rdata (mem_read_data),
        .i_split     (r_state == StSplit),
        .i_lane      (r_cnt),
        .i_size      (r_size),
        .i_signed    (r_signed),
        .o_asm_next  (w_asm_next),
        .o_rdata     (w_ext)
    );

    assign rsp_valid = (r_state == StResp);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && !r_err && !r_write) ? w_ext : 32'd0;

endmodule
